// File: rtl/uart_frame_rx_ctrl.sv
//------------------------------------------------------------------------------
// Module  : uart_frame_rx_ctrl
// Brief   : Parses 6-byte command frames (HDR0 HDR1 CMD ADDR DATA CHK) from a
//           UART byte receiver; issues register writes or baud changes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_rx_ctrl #(
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter logic [7:0] HDR0           = 8'h55,
    parameter logic [7:0] HDR1           = 8'hA5,
    parameter logic [2:0] BAUD_DEFAULT   = 3'd4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [2:0] baud_set,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_H1  = 3'd1,
        S_GET_CMD  = 3'd2,
        S_GET_ADDR = 3'd3,
        S_GET_DATA = 3'd4,
        S_GET_CHK  = 3'd5,
        S_EXEC     = 3'd6
    } state_t;

    state_t           state_q;
    logic             byte_vld_q;
    logic [7:0]       cmd_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic [7:0]       acc_q;
    logic [CNT_W-1:0] gap_q;
    logic [2:0]       baud_q;
    logic             reg_wr_en_q;
    logic [7:0]       reg_addr_q;
    logic [7:0]       reg_wdata_q;
    logic             frame_ok_q;
    logic             frame_err_q;
    logic [7:0]       err_cnt_q;

    logic [7:0]       acc_d;
    logic             is_wr_d;
    logic             baud_ok_d;
    logic             gap_run_d;
    logic             timeout_d;

    assign acc_d     = acc_q + rx_data;
    assign is_wr_d   = (cmd_q == 8'h01);
    assign baud_ok_d = (cmd_q == 8'h02) && (data_q <= 8'd4);
    assign gap_run_d = (state_q != S_IDLE) && (state_q != S_EXEC);
    // A byte landing on the terminal count wins over the timeout.
    assign timeout_d = gap_run_d && !byte_vld_q && (gap_q == GAP_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            byte_vld_q  <= 1'b0;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            acc_q       <= 8'h00;
            gap_q       <= '0;
            baud_q      <= BAUD_DEFAULT;
            reg_wr_en_q <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= rx_done;
            reg_wr_en_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (!gap_run_d || byte_vld_q) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (byte_vld_q && rx_data == HDR0) begin
                        state_q <= S_WAIT_H1;
                    end
                end
                S_WAIT_H1: begin
                    if (byte_vld_q) begin
                        if (rx_data == HDR1) begin
                            state_q <= S_GET_CMD;
                        end else if (rx_data != HDR0) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GET_CMD: begin
                    if (byte_vld_q) begin
                        cmd_q   <= rx_data;
                        acc_q   <= rx_data;
                        state_q <= S_GET_ADDR;
                    end
                end
                S_GET_ADDR: begin
                    if (byte_vld_q) begin
                        addr_q  <= rx_data;
                        acc_q   <= acc_d;
                        state_q <= S_GET_DATA;
                    end
                end
                S_GET_DATA: begin
                    if (byte_vld_q) begin
                        data_q  <= rx_data;
                        acc_q   <= acc_d;
                        state_q <= S_GET_CHK;
                    end
                end
                S_GET_CHK: begin
                    if (byte_vld_q) begin
                        if (rx_data == acc_q) begin
                            // Pulses are registered on entry so they are high during EXEC.
                            state_q <= S_EXEC;
                            if (is_wr_d) begin
                                reg_wr_en_q <= 1'b1;
                                reg_addr_q  <= addr_q;
                                reg_wdata_q <= data_q;
                                frame_ok_q  <= 1'b1;
                            end else if (baud_ok_d) begin
                                frame_ok_q  <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_EXEC: begin
                    if (baud_ok_d) begin
                        baud_q <= data_q[2:0];
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (timeout_d) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
                gap_q       <= '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt_q <= 8'h00;
        end else if (frame_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign baud_set  = baud_q;
    assign reg_wr_en = reg_wr_en_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_rx_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_frame_rx_ctrl
// Brief   : Self-checking bench for uart_frame_rx_ctrl (frame table + scoreboard).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_frame_rx_ctrl;

    localparam int TO    = 100;
    localparam int K_WR  = 0;
    localparam int K_BD  = 1;
    localparam int K_ERR = 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [2:0] baud_set;
    logic       reg_wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_cnt;

    uart_frame_rx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .baud_set (baud_set),
        .reg_wr_en(reg_wr_en),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_cnt  (err_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
        int         tol;
    } exp_t;

    typedef struct {
        logic [47:0] bytes;
        int          kind;
        logic [7:0]  addr;
        logic [7:0]  data;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done = 0;
    bit bn_pending = 1'b0;
    int bn_val = 0;

    int m_addr = 0;
    int m_data = 0;
    int m_baud = 4;
    int m_ecnt = 0;

    task automatic chk(input string nm, input bit ok, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_eq(input string nm, input int act, input int exp);
        chk(nm, act == exp, act, exp);
    endtask

    function automatic exp_t mk(input int kind, input logic [7:0] a, input logic [7:0] d, input int tol);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.cyc  = 0;
        e.tol  = tol;
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        int   k;
        int   dc;
        if (bn_pending) begin
            chk_eq("baud_after_exec", int'(baud_set), bn_val);
            bn_pending = 1'b0;
        end
        if (frame_ok && frame_err) begin
            chk_eq("ok_err_exclusive", 1, 0);
        end
        if (reg_wr_en || frame_ok || frame_err) begin
            if (frame_err)                   k = K_ERR;
            else if (reg_wr_en && frame_ok)  k = K_WR;
            else if (frame_ok)               k = K_BD;
            else                             k = 3;
            if (sb.size() == 0) begin
                chk_eq("unexpected_pulse", k, -1);
            end else begin
                e = sb.pop_front();
                dc = cyc - e.cyc;
                chk_eq("pulse_kind", k, e.kind);
                chk("pulse_cycle", (dc <= e.tol) && (dc >= -e.tol), cyc, e.cyc);
                if (e.kind == K_WR) begin
                    chk_eq("wr_addr", int'(reg_addr), int'(e.addr));
                    chk_eq("wr_data", int'(reg_wdata), int'(e.data));
                end
                if (e.kind == K_BD) begin
                    chk_eq("baud_in_exec", int'(baud_set), m_baud);
                    bn_pending = 1'b1;
                    bn_val = int'(e.data);
                end
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge Clk);
        monitor();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit has_exp, input exp_t e);
        exp_t ee;
        ee = e;
        rx_done = 1'b1;
        last_done = cyc;
        if (has_exp) begin
            ee.cyc = cyc + 2;
            sb.push_back(ee);
        end
        tick();
        rx_done = 1'b0;
        rx_data = b;
        tick();
        repeat (3) tick();
    endtask

    task automatic send_frame(input logic [47:0] bytes, input int kind, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e = mk(kind, a, d, 0);
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[47-8*i -: 8], i == 5, e);
        end
    endtask

    task automatic model_update(input int kind, input logic [7:0] a, input logic [7:0] d);
        if (kind == K_WR) begin
            m_addr = int'(a);
            m_data = int'(d);
        end else if (kind == K_BD) begin
            m_baud = int'(d);
        end else if (m_ecnt < 255) begin
            m_ecnt++;
        end
    endtask

    task automatic check_state(input string tag);
        chk_eq({tag, "_sb_empty"}, sb.size(), 0);
        chk_eq({tag, "_baud"}, int'(baud_set), m_baud);
        chk_eq({tag, "_err_cnt"}, int'(err_cnt), m_ecnt);
        chk_eq({tag, "_reg_addr"}, int'(reg_addr), m_addr);
        chk_eq({tag, "_reg_wdata"}, int'(reg_wdata), m_data);
    endtask

    initial begin
        exp_t none;
        none = mk(K_ERR, 8'h00, 8'h00, 0);

        vecs[0] = '{48'h55A501103C4D, K_WR,  8'h10, 8'h3C};
        vecs[1] = '{48'h55A502000103, K_BD,  8'h00, 8'h01};
        vecs[2] = '{48'h55A501103C4E, K_ERR, 8'h00, 8'h00};
        vecs[3] = '{48'h55A502000709, K_ERR, 8'h00, 8'h00};
        vecs[4] = '{48'h55A502000507, K_ERR, 8'h00, 8'h00};
        vecs[5] = '{48'h55A502000406, K_BD,  8'h00, 8'h04};
        vecs[6] = '{48'h55A503112236, K_ERR, 8'h00, 8'h00};
        vecs[7] = '{48'h55A501F02011, K_WR,  8'hF0, 8'h20};
        vecs[8] = '{48'h55A502000204, K_BD,  8'h00, 8'h02};

        Reset_n = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        chk_eq("rst_baud", int'(baud_set), 4);
        chk_eq("rst_wr_en", int'(reg_wr_en), 0);
        chk_eq("rst_ok", int'(frame_ok), 0);
        chk_eq("rst_err", int'(frame_err), 0);
        chk_eq("rst_err_cnt", int'(err_cnt), 0);
        chk_eq("rst_addr", int'(reg_addr), 0);
        Reset_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].bytes, vecs[v].kind, vecs[v].addr, vecs[v].data);
            repeat (4) tick();
            model_update(vecs[v].kind, vecs[v].addr, vecs[v].data);
            check_state($sformatf("vec%0d", v));
        end

        // Stray byte and repeated HDR0 ahead of a valid frame.
        begin
            logic [63:0] rs;
            rs = 64'h005555A501200122;
            for (int i = 0; i < 8; i++) begin
                send_byte(rs[63-8*i -: 8], i == 7, mk(K_WR, 8'h20, 8'h01, 0));
            end
            repeat (4) tick();
            model_update(K_WR, 8'h20, 8'h01);
            check_state("resync");
        end

        // Inter-byte timeout after CMD.
        send_byte(8'h55, 1'b0, none);
        send_byte(8'hA5, 1'b0, none);
        send_byte(8'h01, 1'b0, none);
        begin
            exp_t e;
            e = mk(K_ERR, 8'h00, 8'h00, 1);
            e.cyc = last_done + 2 + TO;
            sb.push_back(e);
        end
        repeat (TO + 20) tick();
        model_update(K_ERR, 8'h00, 8'h00);
        check_state("timeout");
        send_frame(48'h55A501334478, K_WR, 8'h33, 8'h44);
        repeat (4) tick();
        model_update(K_WR, 8'h33, 8'h44);
        check_state("post_timeout");

        // Error counter saturation.
        for (int n = 0; n < 300; n++) begin
            send_frame(48'h55A501103C4E, K_ERR, 8'h00, 8'h00);
            model_update(K_ERR, 8'h00, 8'h00);
        end
        repeat (4) tick();
        check_state("saturate");
        chk_eq("saturate_255", int'(err_cnt), 255);

        // Asynchronous reset in the middle of a frame.
        send_byte(8'h55, 1'b0, none);
        send_byte(8'hA5, 1'b0, none);
        send_byte(8'h02, 1'b0, none);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_eq("mid_rst_baud", int'(baud_set), 4);
        chk_eq("mid_rst_err_cnt", int'(err_cnt), 0);
        chk_eq("mid_rst_addr", int'(reg_addr), 0);
        chk_eq("mid_rst_wdata", int'(reg_wdata), 0);
        chk_eq("mid_rst_pulses", int'({reg_wr_en, frame_ok, frame_err}), 0);
        m_addr = 0;
        m_data = 0;
        m_baud = 4;
        m_ecnt = 0;
        bn_pending = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        repeat (2) tick();
        send_frame(48'h55A501103C4D, K_WR, 8'h10, 8'h3C);
        repeat (4) tick();
        model_update(K_WR, 8'h10, 8'h3C);
        check_state("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
